// File: rtl/i2c_regfile_ctrl.sv
// Register bank shared by an I2C slave port (strobe-only, always wins) and one
// fabric requester (req/gnt, held off while I2C writes). Upper registers are sticky status.
module i2c_regfile_ctrl #(
    parameter int         NUM_REGS = 16,
    parameter int         RO_BASE  = 12,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        i2c_addr_i,
    input  logic [7:0]                        i2c_wdata_i,
    input  logic                              i2c_wr_i,
    input  logic                              i2c_rd_i,
    output logic [7:0]                        i2c_rdata_o,
    input  logic                              lcl_req_i,
    input  logic                              lcl_we_i,
    input  logic [7:0]                        lcl_addr_i,
    input  logic [7:0]                        lcl_wdata_i,
    output logic                              lcl_gnt_o,
    output logic                              lcl_rvalid_o,
    output logic [7:0]                        lcl_rdata_o,
    input  logic [8*(NUM_REGS-RO_BASE)-1:0]   sts_i,
    output logic                              wr_evt_o,
    output logic [7:0]                        wr_evt_addr_o,
    output logic                              err_o
);

    localparam int         IDX_W      = $clog2(NUM_REGS);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);
    localparam logic [7:0] RO_BASE_B  = 8'(RO_BASE);

    typedef enum logic [1:0] {
        L_IDLE,
        L_WAIT,
        L_RESP
    } lstate_e;

    lstate_e    state_q;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];
    logic [7:0] lcl_rdata_q;
    logic       lcl_rvalid_q;
    logic       wr_evt_q;
    logic [7:0] wr_evt_addr_q;
    logic       err_q;
    logic       err_d;

    logic       lcl_fire;
    logic       lcl_rd_fire;
    logic       i2c_wr_ok;
    logic       lcl_wr_ok;
    logic [7:0] lcl_rd_val;

    // The fabric only proceeds in cycles without an I2C write, so the two
    // ports can never write the bank on the same edge.
    assign lcl_fire    = !i2c_wr_i && ((state_q == L_IDLE && lcl_req_i) || state_q == L_WAIT);
    assign lcl_rd_fire = lcl_fire && !lcl_we_i;
    assign i2c_wr_ok   = i2c_wr_i && (i2c_addr_i < RO_BASE_B);
    assign lcl_wr_ok   = lcl_fire && lcl_we_i && (lcl_addr_i < RO_BASE_B);

    assign err_d = err_q
                 | (i2c_wr_i && !(i2c_addr_i < RO_BASE_B))
                 | (lcl_fire && lcl_we_i && !(lcl_addr_i < RO_BASE_B));

    assign i2c_rdata_o = (i2c_addr_i < NUM_REGS_B) ? regs_q[i2c_addr_i[IDX_W-1:0]] : 8'h00;
    assign lcl_rd_val  = (lcl_addr_i < NUM_REGS_B) ? regs_q[lcl_addr_i[IDX_W-1:0]] : 8'h00;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi < RO_BASE) begin : g_rw
                assign regs_d[gi] = (i2c_wr_ok && i2c_addr_i == 8'(gi)) ? i2c_wdata_i :
                                    (lcl_wr_ok && lcl_addr_i == 8'(gi)) ? lcl_wdata_i :
                                    regs_q[gi];
            end else begin : g_sts
                logic clr;
                assign clr = i2c_rd_i && (i2c_addr_i == 8'(gi));
                // Set pulses are OR'd after the clear so a coincident set survives.
                assign regs_d[gi] = (clr ? 8'h00 : regs_q[gi]) | sts_i[(gi-RO_BASE)*8 +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i < RO_BASE) ? RST_VAL : 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= L_IDLE;
            lcl_rdata_q   <= 8'h00;
            lcl_rvalid_q  <= 1'b0;
            wr_evt_q      <= 1'b0;
            wr_evt_addr_q <= 8'h00;
            err_q         <= 1'b0;
        end else begin
            lcl_rvalid_q <= lcl_rd_fire;
            if (lcl_rd_fire) begin
                lcl_rdata_q <= lcl_rd_val;
            end
            wr_evt_q <= i2c_wr_ok;
            if (i2c_wr_ok) begin
                wr_evt_addr_q <= i2c_addr_i;
            end
            err_q <= err_d;
            case (state_q)
                L_IDLE: begin
                    if (lcl_req_i) begin
                        if (i2c_wr_i)      state_q <= L_WAIT;
                        else if (lcl_we_i) state_q <= L_IDLE;
                        else               state_q <= L_RESP;
                    end
                end
                L_WAIT: begin
                    if (!i2c_wr_i) begin
                        state_q <= lcl_we_i ? L_IDLE : L_RESP;
                    end
                end
                L_RESP:  state_q <= L_IDLE;
                default: state_q <= L_IDLE;
            endcase
        end
    end

    assign lcl_gnt_o     = lcl_fire;
    assign lcl_rvalid_o  = lcl_rvalid_q;
    assign lcl_rdata_o   = lcl_rdata_q;
    assign wr_evt_o      = wr_evt_q;
    assign wr_evt_addr_o = wr_evt_addr_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// Directed, table-driven bench for i2c_regfile_ctrl: one row per clock cycle,
// outputs compared at the falling edge while the row's inputs are applied.
module tb_i2c_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i2c_addr, i2c_wdata, i2c_rdata;
    logic        i2c_wr, i2c_rd;
    logic        lcl_req, lcl_we, lcl_gnt, lcl_rvalid;
    logic [7:0]  lcl_addr, lcl_wdata, lcl_rdata;
    logic [31:0] sts;
    logic        wr_evt, err;
    logic [7:0]  wr_evt_addr;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    i2c_regfile_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i2c_addr_i(i2c_addr), .i2c_wdata_i(i2c_wdata), .i2c_wr_i(i2c_wr), .i2c_rd_i(i2c_rd),
        .i2c_rdata_o(i2c_rdata),
        .lcl_req_i(lcl_req), .lcl_we_i(lcl_we), .lcl_addr_i(lcl_addr), .lcl_wdata_i(lcl_wdata),
        .lcl_gnt_o(lcl_gnt), .lcl_rvalid_o(lcl_rvalid), .lcl_rdata_o(lcl_rdata),
        .sts_i(sts), .wr_evt_o(wr_evt), .wr_evt_addr_o(wr_evt_addr), .err_o(err)
    );

    typedef struct {
        logic        wr, rd;
        logic [7:0]  addr, wdata;
        logic        req, we;
        logic [7:0]  laddr, lwdata;
        logic [31:0] sts;
        logic        e_gnt, e_rv;
        logic [7:0]  e_lrd;
        logic        chk_evt, e_evt;
        logic [7:0]  e_evt_addr;
        logic        e_err;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vt [25];

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i2c_wr = 0; i2c_rd = 0; i2c_addr = 0; i2c_wdata = 0;
        lcl_req = 0; lcl_we = 0; lcl_addr = 0; lcl_wdata = 0; sts = 0;
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic req, input logic we,
                                input logic [7:0] laddr, input logic [7:0] lwdata,
                                input logic [31:0] s, input logic e_gnt, input logic e_rv,
                                input logic [7:0] e_lrd, input logic chk_evt, input logic e_evt,
                                input logic [7:0] e_evt_addr, input logic e_err,
                                input logic [7:0] e_rdata);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
        v.req = req; v.we = we; v.laddr = laddr; v.lwdata = lwdata; v.sts = s;
        v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_lrd = e_lrd;
        v.chk_evt = chk_evt; v.e_evt = e_evt; v.e_evt_addr = e_evt_addr;
        v.e_err = e_err; v.e_rdata = e_rdata;
        return v;
    endfunction

    initial begin
        // wr rd addr wdata | req we laddr lwdata | sts | gnt rv lrd | chk evt evtaddr | err rdata
        vt[0]  = mk(0,0,8'd0, 8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,0,8'd0, 0,8'h00);
        vt[1]  = mk(0,0,8'd11,8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,0,8'd0, 0,8'h00);
        vt[2]  = mk(1,0,8'd3, 8'hA5, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,0,8'd0, 0,8'h00);
        vt[3]  = mk(0,0,8'd3, 8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,1,8'd3, 0,8'hA5);
        vt[4]  = mk(1,0,8'd2, 8'h77, 1,1,8'd5, 8'h3C, 32'h0,        0,0,8'h00, 1,0,8'd0, 0,8'h00);
        vt[5]  = mk(0,0,8'd2, 8'h00, 1,1,8'd5, 8'h3C, 32'h0,        1,0,8'h00, 1,1,8'd2, 0,8'h77);
        vt[6]  = mk(0,0,8'd5, 8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,0,8'd0, 0,8'h3C);
        vt[7]  = mk(0,0,8'd3, 8'h00, 1,0,8'd3, 8'h00, 32'h0,        1,0,8'h00, 1,0,8'd0, 0,8'hA5);
        vt[8]  = mk(0,0,8'd3, 8'h00, 1,0,8'd5, 8'h00, 32'h0,        0,1,8'hA5, 1,0,8'd0, 0,8'hA5);
        vt[9]  = mk(0,0,8'd3, 8'h00, 1,0,8'd5, 8'h00, 32'h0,        1,0,8'h00, 1,0,8'd0, 0,8'hA5);
        vt[10] = mk(0,0,8'd5, 8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,1,8'h3C, 1,0,8'd0, 0,8'h3C);
        vt[11] = mk(0,0,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h1,        0,0,8'h00, 1,0,8'd0, 0,8'h00);
        vt[12] = mk(0,1,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,0,8'd0, 0,8'h01);
        vt[13] = mk(0,0,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,0,8'd0, 0,8'h00);
        vt[14] = mk(0,0,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h1,        0,0,8'h00, 1,0,8'd0, 0,8'h00);
        vt[15] = mk(0,1,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h1,        0,0,8'h00, 1,0,8'd0, 0,8'h01);
        vt[16] = mk(0,0,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h80000000, 0,0,8'h00, 1,0,8'd0, 0,8'h01);
        vt[17] = mk(0,0,8'd15,8'h00, 1,0,8'd12,8'h00, 32'h0,        1,0,8'h00, 1,0,8'd0, 0,8'h80);
        vt[18] = mk(0,0,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,1,8'h01, 1,0,8'd0, 0,8'h01);
        vt[19] = mk(0,0,8'd13,8'h00, 1,1,8'd20,8'h55, 32'h0,        1,0,8'h00, 1,0,8'd0, 0,8'h00);
        vt[20] = mk(0,0,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,0,8'd0, 1,8'h01);
        vt[21] = mk(1,0,8'd12,8'hFF, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 1,0,8'd0, 1,8'h01);
        vt[22] = mk(0,0,8'd12,8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,0,8'h00, 0,0,8'd0, 1,8'h01);
        vt[23] = mk(0,0,8'd20,8'h00, 1,0,8'd20,8'h00, 32'h0,        1,0,8'h00, 1,0,8'd0, 1,8'h00);
        vt[24] = mk(0,0,8'd15,8'h00, 0,0,8'd0, 8'h00, 32'h0,        0,1,8'h00, 1,0,8'd0, 1,8'h80);

        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        foreach (vt[i]) begin
            i2c_wr = vt[i].wr; i2c_rd = vt[i].rd; i2c_addr = vt[i].addr; i2c_wdata = vt[i].wdata;
            lcl_req = vt[i].req; lcl_we = vt[i].we; lcl_addr = vt[i].laddr; lcl_wdata = vt[i].lwdata;
            sts = vt[i].sts;
            @(negedge clk);
            check("lcl_gnt",   i, {7'd0, lcl_gnt},    {7'd0, vt[i].e_gnt});
            check("lcl_rvalid",i, {7'd0, lcl_rvalid}, {7'd0, vt[i].e_rv});
            if (vt[i].e_rv) check("lcl_rdata", i, lcl_rdata, vt[i].e_lrd);
            if (vt[i].chk_evt) begin
                check("wr_evt", i, {7'd0, wr_evt}, {7'd0, vt[i].e_evt});
                if (vt[i].e_evt) check("wr_evt_addr", i, wr_evt_addr, vt[i].e_evt_addr);
            end
            check("err",       i, {7'd0, err},        {7'd0, vt[i].e_err});
            check("i2c_rdata", i, i2c_rdata,          vt[i].e_rdata);
            $display("row %0d: i2c wr=%0b rd=%0b a=%0d | lcl req=%0b we=%0b a=%0d | gnt=%0b rv=%0b rdata=%h",
                     i, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].req, vt[i].we, vt[i].laddr,
                     lcl_gnt, lcl_rvalid, i2c_rdata);
            @(posedge clk);
            #1;
        end

        // Reset between a read grant and its response: no rvalid, bank and err cleared.
        idle_inputs();
        lcl_req = 1; lcl_addr = 8'd3;
        @(negedge clk);
        check("rst_gnt", 100, {7'd0, lcl_gnt}, 8'd1);
        @(posedge clk);
        #1 rst_n = 0; lcl_req = 0; i2c_addr = 8'd3;
        @(negedge clk);
        check("rst_rvalid", 101, {7'd0, lcl_rvalid}, 8'd0);
        check("rst_err",    101, {7'd0, err},        8'd0);
        check("rst_reg3",   101, i2c_rdata,          8'h00);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("post_rst_rvalid", 102, {7'd0, lcl_rvalid}, 8'd0);
        check("post_rst_gnt",    102, {7'd0, lcl_gnt},    8'd0);
        $display("seq reset-mid-access: rvalid=%0b err=%0b reg3=%h", lcl_rvalid, err, i2c_rdata);

        // Out-of-range I2C write after reset: dropped, raises sticky err.
        @(posedge clk);
        #1 i2c_wr = 1; i2c_addr = 8'd200; i2c_wdata = 8'h99;
        @(posedge clk);
        #1 i2c_wr = 0; i2c_addr = 8'd0;
        @(negedge clk);
        check("oor_err",   103, {7'd0, err},    8'd1);
        check("oor_evt",   103, {7'd0, wr_evt}, 8'd0);
        check("oor_reg0",  103, i2c_rdata,      8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 104, {7'd0, err},   8'd1);
        $display("seq oor-write: err=%0b", err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
